latch_write_ctrl: RTL and testbench



---
 rtl/latch_write_ctrl.sv | 148 ++++++++++++++
 tb/tb_latch_write_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/latch_write_ctrl.sv
// Write/clear sequencer for a bank of level-sensitive D latches: setup, gate pulse, hold.
// Optional readback compare of lat_q enabled by defining LATCH_READBACK_CHECK_EN (adds wr_err).
module latch_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_clr,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_g,
  output logic             lat_rst,
  output logic             busy,
  output logic             done,
`ifdef LATCH_READBACK_CHECK_EN
  output logic             wr_err,
`endif
  input  logic [WIDTH-1:0] lat_q
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
    $fatal(1, "latch_write_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW   = ($clog2(MAXC + 1) < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CLR} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             gate_q, gate_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic             last;
  logic             rb_mis;

  assign last = (cnt_q == '0);

`ifdef LATCH_READBACK_CHECK_EN
  logic err_q, err_d;
  // HOLD checks the written word; CLR expects an all-zero bank.
  assign rb_mis = (state_q == HOLD) ? (lat_q != dat_q) : (lat_q != '0);
  assign wr_err = err_q;
`else
  logic unused_lat_q;
  assign unused_lat_q = ^lat_q;
  assign rb_mis       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    gate_d  = gate_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
`ifdef LATCH_READBACK_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_clr) begin
            clr_d   = 1'b1;
            dat_d   = '0;
            cnt_d   = PULSE_LD;
            state_d = CLR;
          end else begin
            dat_d   = req_data;
            cnt_d   = SETUP_LD;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (last) begin
          gate_d  = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else cnt_d = cnt_q - 1'b1;
      end
      PULSE: begin
        if (last) begin
          gate_d  = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else cnt_d = cnt_q - 1'b1;
      end
      HOLD, CLR: begin
        if (last) begin
          clr_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef LATCH_READBACK_CHECK_EN
          err_d   = rb_mis;
`endif
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      gate_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef LATCH_READBACK_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      gate_q  <= gate_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
`ifdef LATCH_READBACK_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // The request is only accepted in IDLE, so IDLE's req_valid is the acceptance.
  assign req_ready = rst & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign lat_d     = dat_q;
  assign lat_g     = gate_q;
  assign lat_rst   = clr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Bench for latch_write_ctrl: directed and random write/clear ops checked against a
// per-cycle timing model derived from the setup/pulse/hold rules.
module tb_latch_write_ctrl;
  localparam int W = 8;
  localparam int S = 2;
  localparam int P = 3;
  localparam int H = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_clr = 1'b0;
  logic [W-1:0] req_data = '0;
  logic         req_ready, lat_g, lat_rst, busy, done;
  logic [W-1:0] lat_d, lat_q;
  logic [W-1:0] lat_store = '0;
  logic         corrupt = 1'b0;
  logic [W-1:0] exp_d = '0;
  logic         wr_err_obs;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

`ifdef LATCH_READBACK_CHECK_EN
  logic wr_err;
  assign wr_err_obs = wr_err;
`else
  assign wr_err_obs = 1'b0;
`endif

  latch_write_ctrl #(.WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_clr(req_clr), .req_data(req_data), .lat_d(lat_d), .lat_g(lat_g),
    .lat_rst(lat_rst), .busy(busy), .done(done),
`ifdef LATCH_READBACK_CHECK_EN
    .wr_err(wr_err),
`endif
    .lat_q(lat_q)
  );

  // Latch bank model: control lines are registered, so mid-cycle sampling is exact.
  always @(negedge clk) begin
    if (lat_rst) lat_store <= '0;
    else if (lat_g) lat_store <= lat_d;
  end
  assign lat_q = corrupt ? '0 : lat_store;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph, input logic [W-1:0] d, input logic g, input logic r,
                         input logic dn, input logic bz, input logic rdy, input logic er);
    chk({ph, " lat_d"}, lat_d, d);
    chk({ph, " lat_g"}, lat_g, g);
    chk({ph, " lat_rst"}, lat_rst, r);
    chk({ph, " done"}, done, dn);
    chk({ph, " busy"}, busy, bz);
    chk({ph, " req_ready"}, req_ready, rdy);
`ifdef LATCH_READBACK_CHECK_EN
    chk({ph, " wr_err"}, wr_err_obs, er);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is high.
  // With keep=1, req_valid stays high so the caller's next op is taken on the done cycle.
  task automatic do_op(input logic clr, input logic [W-1:0] data, input logic keep, input logic bad);
    int   len;
    logic experr;
    len     = clr ? P : S + P + H;
    experr  = bad && !clr && (data != '0);
    corrupt = bad;
    req_valid = 1'b1;
    req_clr   = clr;
    req_data  = data;
    chk("pre-accept req_ready", req_ready, 1'b1);
    exp_d = clr ? '0 : data;
    for (int n = 0; n <= len; n++) begin
      @(negedge clk);
      if (n == 0) begin
        req_valid = keep;
        req_data  = W'($urandom);
        req_clr   = 1'($urandom);
      end
      chk_all($sformatf("%s n=%0d", clr ? "clr" : "wr", n), exp_d,
              !clr && n >= S && n < S + P, clr && n < P,
              n == len, n < len, n == len, (n == len) && experr);
    end
  endtask

  task automatic idle_cycles(input int k);
    req_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk_all("idle", exp_d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic clr, keep, bad;
    logic [W-1:0] data;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    #1 chk("post-reset req_ready", req_ready, 1'b1);
    exp_d = '0;

    do_op(1'b0, 8'hA5, 1'b0, 1'b0);
    do_op(1'b1, 8'hFF, 1'b0, 1'b0);
    idle_cycles(2);

    // Back-to-back writes with req_valid held high
    do_op(1'b0, 8'h3C, 1'b1, 1'b0);
    do_op(1'b0, 8'h0F, 1'b0, 1'b0);
    idle_cycles(1);

    // Reset in the middle of the gate pulse
    req_valid = 1'b1;
    req_clr   = 1'b0;
    req_data  = 8'h96;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S + 1) @(negedge clk);
    chk("mid-pulse lat_g", lat_g, 1'b1);
    #2 rst = 1'b0;
    #1 chk_all("abort", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_all("abort hold", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    exp_d = '0;
    idle_cycles(1);
    do_op(1'b0, 8'h5A, 1'b0, 1'b0);

`ifdef LATCH_READBACK_CHECK_EN
    do_op(1'b0, 8'h55, 1'b0, 1'b1);
    do_op(1'b0, 8'h55, 1'b0, 1'b0);
`endif

    // Random mix of writes, clears, back-to-back and idle gaps
    for (int i = 0; i < 20; i++) begin
      clr  = ($urandom_range(0, 3) == 0);
      data = W'($urandom);
      keep = 1'($urandom_range(0, 1));
`ifdef LATCH_READBACK_CHECK_EN
      bad  = 1'($urandom_range(0, 1));
`else
      bad  = 1'b0;
`endif
      do_op(clr, data, keep, bad);
      if (!keep) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);
    corrupt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
